pipe: RTL and testbench



---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_reg.sv | 20 ++
 rtl/pipe.sv | 61 ++++++
 tb/tb_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared width, latency and word type for the pipe datapath
package pipe_pkg;

  // Default operand/result width
  localparam int PIPE_W = 10;

  // Rising edges from operand sampling to result on F
  localparam int PIPE_LAT = 3;

  typedef logic [PIPE_W-1:0] word_t;

endpackage : pipe_pkg

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - plain W-bit register with synchronous active-high clear
module pipe_reg #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // Load every edge; rst forces the stored value to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= '0;
    end else begin
      q_o <= d_i;
    end
  end

endmodule : pipe_reg

// File: rtl/pipe.sv
// rtl/pipe.sv - 3-stage pipelined F = ((A+B)+(C-D))*D; optional valid chain under PIPE_VALID_EN
module pipe
  import pipe_pkg::*;
#(
  parameter int N = PIPE_W
) (
  input  logic         clk,
  input  logic         rst,
`ifdef PIPE_VALID_EN
  input  logic         in_valid,
`endif
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  input  logic [N-1:0] D,
`ifdef PIPE_VALID_EN
  output logic         out_valid,
`endif
  output logic [N-1:0] F
);

  logic [N-1:0] x1_d, x1_q;
  logic [N-1:0] x2_d, x2_q;
  logic [N-1:0] d1_q;
  logic [N-1:0] x3_d, x3_q;
  logic [N-1:0] d2_q;
  logic [N-1:0] f_d, f_q;

  // All arithmetic is modulo 2^N: results are assigned into N-bit nets,
  // so carries and the upper half of the product are simply dropped.
  assign x1_d = A + B;
  assign x2_d = C - D;
  assign x3_d = x1_q + x2_q;
  assign f_d  = x3_q * d2_q;

  // Stage 1: operand sums/differences and the multiplier copy
  pipe_reg #(.W(N)) u_x1 (.clk(clk), .rst(rst), .d_i(x1_d), .q_o(x1_q));
  pipe_reg #(.W(N)) u_x2 (.clk(clk), .rst(rst), .d_i(x2_d), .q_o(x2_q));
  pipe_reg #(.W(N)) u_d1 (.clk(clk), .rst(rst), .d_i(D),    .q_o(d1_q));

  // Stage 2: combine the two partial terms, carry the multiplier along
  pipe_reg #(.W(N)) u_x3 (.clk(clk), .rst(rst), .d_i(x3_d), .q_o(x3_q));
  pipe_reg #(.W(N)) u_d2 (.clk(clk), .rst(rst), .d_i(d1_q), .q_o(d2_q));

  // Stage 3: truncated product is the registered result
  pipe_reg #(.W(N)) u_f  (.clk(clk), .rst(rst), .d_i(f_d),  .q_o(f_q));

  assign F = f_q;

`ifdef PIPE_VALID_EN
  logic v1_q, v2_q, v3_q;

  // Valid bits ride alongside the data; data registers ignore them
  pipe_reg #(.W(1)) u_v1 (.clk(clk), .rst(rst), .d_i(in_valid), .q_o(v1_q));
  pipe_reg #(.W(1)) u_v2 (.clk(clk), .rst(rst), .d_i(v1_q),     .q_o(v2_q));
  pipe_reg #(.W(1)) u_v3 (.clk(clk), .rst(rst), .d_i(v2_q),     .q_o(v3_q));

  assign out_valid = v3_q;
`endif

endmodule : pipe

// File: tb/tb_pipe.sv
// tb/tb_pipe.sv - randomized and directed self-checking bench for pipe
module tb_pipe;
  import pipe_pkg::*;

  typedef struct {
    word_t f;
    logic  v;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  word_t A = '0, B = '0, C = '0, D = '0;
  word_t F;
`ifdef PIPE_VALID_EN
  logic  vin = 1'b0;
  logic  vout;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe #(.N(PIPE_W)) dut (
    .clk(clk),
    .rst(rst),
`ifdef PIPE_VALID_EN
    .in_valid(vin),
    .out_valid(vout),
`endif
    .A(A),
    .B(B),
    .C(C),
    .D(D),
    .F(F)
  );

  function automatic word_t rnd();
    return word_t'($urandom);
  endfunction

  function automatic word_t model_f(input word_t a, input word_t b, input word_t c, input word_t d);
    int t;
    t = ((int'(a) + int'(b)) + (int'(c) - int'(d))) * int'(d);
    t = ((t % (1 << PIPE_W)) + (1 << PIPE_W)) % (1 << PIPE_W);
    return word_t'(t);
  endfunction

  task automatic cycle(input word_t a, input word_t b, input word_t c, input word_t d,
                       input logic v, input logic r, output logic have, output exp_t e);
    A = a; B = b; C = c; D = d; rst = r;
`ifdef PIPE_VALID_EN
    vin = v;
`endif
    @(posedge clk);
    #1;
    have = 1'b0;
    e = '{f: '0, v: 1'b0};
    if (r) begin
      exp_q.delete();
      for (int i = 0; i < PIPE_LAT - 1; i++) exp_q.push_back('{f: '0, v: 1'b0});
      have = 1'b1;
    end else begin
      exp_q.push_back('{f: model_f(a, b, c, d), v: v});
      if (exp_q.size() >= PIPE_LAT) begin
        e = exp_q.pop_front();
        have = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    logic h; exp_t e;
    for (int i = 0; i < 2; i++) begin
      cycle(rnd(), rnd(), rnd(), rnd(), 1'b1, 1'b1, h, e);
      tests_run++;
      if (F !== '0) begin
        tests_failed++;
        $display("FAIL reset_F cycle %0d: got %0d expected 0", i, F);
      end
`ifdef PIPE_VALID_EN
      tests_run++;
      if (vout !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_valid cycle %0d: got %b expected 0", i, vout);
      end
`endif
    end
  endtask

  task automatic test_basic();
    logic h; exp_t e;
    cycle(10, 12, 6, 3, 1'b1, 1'b0, h, e);
    cycle(0, 0, 0, 0, 1'b0, 1'b0, h, e);
    cycle(0, 0, 0, 0, 1'b0, 1'b0, h, e);
    tests_run++;
    if (F !== word_t'(75)) begin
      tests_failed++;
      $display("FAIL basic: got %0d expected 75", F);
    end
  endtask

  task automatic test_stream();
    logic h; exp_t e;
    word_t sa[5] = '{10, 10, 10, 20, 8};
    word_t sb[5] = '{12, 10, 11, 10, 15};
    word_t sc[5] = '{6, 5, 1, 8, 5};
    word_t sd[5] = '{3, 3, 4, 2, 0};
    word_t sf[5] = '{75, 66, 72, 72, 0};
    for (int i = 0; i < 7; i++) begin
      if (i < 5) cycle(sa[i], sb[i], sc[i], sd[i], 1'b1, 1'b0, h, e);
      else       cycle(0, 0, 0, 0, 1'b0, 1'b0, h, e);
      if (i >= 2) begin
        tests_run++;
        if (F !== sf[i-2]) begin
          tests_failed++;
          $display("FAIL stream set %0d: got %0d expected %0d", i - 2, F, sf[i-2]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic h; exp_t e;
    cycle(1000, 1000, 0, 1, 1'b1, 1'b0, h, e);
    cycle(0, 0, 0, 0, 1'b0, 1'b0, h, e);
    cycle(0, 0, 0, 0, 1'b0, 1'b0, h, e);
    tests_run++;
    if (F !== word_t'(975)) begin
      tests_failed++;
      $display("FAIL wrap: got %0d expected 975", F);
    end
  endtask

  task automatic test_zero_mult();
    logic h; exp_t e;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) cycle(rnd(), rnd(), rnd(), 0, 1'b1, 1'b0, h, e);
      else       cycle(rnd(), rnd(), rnd(), rnd(), 1'b0, 1'b0, h, e);
      if (i >= 2 && i < 6) begin
        tests_run++;
        if (F !== '0) begin
          tests_failed++;
          $display("FAIL zero_mult set %0d: got %0d expected 0", i - 2, F);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    logic h; exp_t e;
    cycle(10, 12, 6, 3, 1'b1, 1'b0, h, e);
    cycle(10, 10, 5, 3, 1'b1, 1'b0, h, e);
    cycle(10, 11, 1, 4, 1'b1, 1'b0, h, e);
    cycle(rnd(), rnd(), rnd(), rnd(), 1'b1, 1'b1, h, e);
    tests_run++;
    if (F !== '0) begin
      tests_failed++;
      $display("FAIL midrst_at_reset: got %0d expected 0", F);
    end
    cycle(20, 10, 8, 2, 1'b1, 1'b0, h, e);
    tests_run++;
    if (F !== '0) begin
      tests_failed++;
      $display("FAIL midrst_edge1: got %0d expected 0", F);
    end
    cycle(0, 0, 0, 0, 1'b0, 1'b0, h, e);
    tests_run++;
    if (F !== '0) begin
      tests_failed++;
      $display("FAIL midrst_edge2: got %0d expected 0", F);
    end
    cycle(0, 0, 0, 0, 1'b0, 1'b0, h, e);
    tests_run++;
    if (F !== word_t'(72)) begin
      tests_failed++;
      $display("FAIL midrst_edge3: got %0d expected 72", F);
    end
  endtask

`ifdef PIPE_VALID_EN
  task automatic test_valid();
    logic h; exp_t e;
    logic pat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      cycle(rnd(), rnd(), rnd(), rnd(), pat[i], 1'b0, h, e);
      if (i >= 2) begin
        tests_run++;
        if (vout !== pat[i-2]) begin
          tests_failed++;
          $display("FAIL valid_chain step %0d: got %b expected %b", i - 2, vout, pat[i-2]);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    logic h; exp_t e;
    logic r;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 40) == 0);
      cycle(rnd(), rnd(), rnd(), rnd(), 1'($urandom), r, h, e);
      if (h) begin
        tests_run++;
        if (F !== e.f) begin
          tests_failed++;
          $display("FAIL random_F cycle %0d: got %0d expected %0d", i, F, e.f);
        end
`ifdef PIPE_VALID_EN
        tests_run++;
        if (vout !== e.v) begin
          tests_failed++;
          $display("FAIL random_valid cycle %0d: got %b expected %b", i, vout, e.v);
        end
`endif
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_stream();
    test_wrap();
    test_zero_mult();
    test_reset_mid_stream();
`ifdef PIPE_VALID_EN
    test_valid();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_pipe
